dwnstrm_sched: RTL and testbench

Round-robin scheduler that shares the single downstream order processor between `NUM_REQ` requesters. It accepts one (client_id, amount) request at a time and drives it onto the processor's inputs with a start strobe. It holds those inputs stable for a programmable settle window, because the processor samples on the slower clock. It then captures `cancelled_orders` and returns it to the originating requester over a valid/ready response channel.

---
 rtl/dwnstrm_pkg.sv | 28 ++
 rtl/dwnstrm_sched_rr_arbiter.sv | 47 ++++
 rtl/dwnstrm_sched.sv | 128 ++++++++++++
 tb/tb_dwnstrm_sched.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dwnstrm_pkg.sv
// Shared widths, FSM state encoding and request record for the downstream
// order-processor scheduler.
package dwnstrm_pkg;

   localparam int CLIENT_ID_W = 5;
   localparam int AMOUNT_W    = 16;
   localparam int RESULT_W    = 16;
   localparam int SETTLE_W    = 8;
   localparam int OP_COUNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      SETTLE,
      RESP
   } dwnstrm_state_t;

   typedef struct packed {
      logic [CLIENT_ID_W-1:0] client_id;
      logic [AMOUNT_W-1:0]    amount;
   } dwnstrm_req_t;

   // The counter counts down to zero inclusive, so it starts one below the window.
   function automatic logic [SETTLE_W-1:0] settle_load(input int cycles);
      return SETTLE_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/dwnstrm_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from the slot after
// the last winner; the pointer moves only when a grant is actually taken.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       enable,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] cand_idx;
   logic             found;
   int               cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand     = (int'(last_grant) + k) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            found           = 1'b1;
            grant_idx       = cand_idx;
            grant[cand_idx] = enable;
         end
      end
   end

   // Reset points at the last slot so requester 0 wins first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= IDX_W'(NUM_REQ - 1);
      end else if (enable && |req) begin
         last_grant <= grant_idx;
      end
   end

endmodule

// File: rtl/dwnstrm_sched.sv
// Shares one downstream order processor between NUM_REQ requesters: grant,
// issue with a start strobe, hold inputs for a settle window, return the result.
module dwnstrm_sched
   import dwnstrm_pkg::*;
#(
   parameter int                    NUM_REQ       = 4,
   parameter int                    SETTLE_CYCLES = 4,
   parameter logic [OP_COUNT_W-1:0] OP_COUNT_RST  = '0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*CLIENT_ID_W-1:0]  req_client_id,
   input  logic [NUM_REQ*AMOUNT_W-1:0]     req_amount,
   output logic [CLIENT_ID_W-1:0]          dp_client_id,
   output logic [AMOUNT_W-1:0]             dp_amount,
   output logic                            dp_start,
   input  logic [RESULT_W-1:0]             dp_cancelled_orders,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]      rsp_req_idx,
   output logic [CLIENT_ID_W-1:0]          rsp_client_id,
   output logic [RESULT_W-1:0]             rsp_cancelled,
   output logic                            busy,
   output logic [OP_COUNT_W-1:0]           op_count
);

   localparam int IDX_W = $clog2(NUM_REQ);

   dwnstrm_state_t      state_q, state_d;
   dwnstrm_req_t        reqs [NUM_REQ];
   logic [NUM_REQ-1:0]  grant;
   logic [IDX_W-1:0]    grant_idx;
   logic                arb_en;
   logic                xfer;
   logic                settle_done;
   logic [SETTLE_W-1:0] settle_cnt;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         reqs[i].client_id = req_client_id[i*CLIENT_ID_W +: CLIENT_ID_W];
         reqs[i].amount    = req_amount[i*AMOUNT_W +: AMOUNT_W];
      end
   end

   // Reset also masks the grant so every output reads zero while rst is held.
   assign arb_en = (state_q == IDLE) && !rst;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req_valid),
      .enable    (arb_en),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready     = grant;
   assign xfer          = |grant;
   assign settle_done   = (state_q == SETTLE) && (settle_cnt == '0);
   assign rsp_client_id = dp_client_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      dp_start  = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (xfer) state_d = ISSUE;
         end
         ISSUE: begin
            dp_start = 1'b1;
            state_d  = SETTLE;
         end
         SETTLE: begin
            if (settle_done) state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Processor inputs persist past the response so the slow side never sees them drop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_client_id  <= '0;
         dp_amount     <= '0;
         rsp_req_idx   <= '0;
         rsp_cancelled <= '0;
         settle_cnt    <= '0;
         op_count      <= OP_COUNT_RST;
      end else begin
         if (xfer) begin
            dp_client_id <= reqs[grant_idx].client_id;
            dp_amount    <= reqs[grant_idx].amount;
            rsp_req_idx  <= grant_idx;
         end
         if (state_q == ISSUE) begin
            settle_cnt <= settle_load(SETTLE_CYCLES);
         end else if (state_q == SETTLE && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
         end
         if (settle_done) begin
            rsp_cancelled <= dp_cancelled_orders;
         end
         if (rsp_valid && rsp_ready) begin
            op_count <= op_count + OP_COUNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_dwnstrm_sched.sv
// Directed bench for dwnstrm_sched: a default instance, a one-cycle settle
// instance and an instance whose op counter starts two below its wrap point.
module tb_dwnstrm_sched;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_valid_s1 = '0;
   logic [N-1:0]   req_valid_w = '0;
   logic [N*5-1:0] req_client_id = '0;
   logic [N*16-1:0] req_amount = '0;
   logic [15:0]    dp_cancelled_orders = '0;
   logic           rsp_ready = 1'b0;

   logic [N-1:0] req_ready, req_ready_s1, req_ready_w;
   logic [4:0]   dp_client_id, dp_client_id_s1, dp_client_id_w;
   logic [15:0]  dp_amount, dp_amount_s1, dp_amount_w;
   logic         dp_start, dp_start_s1, dp_start_w;
   logic         rsp_valid, rsp_valid_s1, rsp_valid_w;
   logic [1:0]   rsp_req_idx, rsp_req_idx_s1, rsp_req_idx_w;
   logic [4:0]   rsp_client_id, rsp_client_id_s1, rsp_client_id_w;
   logic [15:0]  rsp_cancelled, rsp_cancelled_s1, rsp_cancelled_w;
   logic         busy, busy_s1, busy_w;
   logic [15:0]  op_count, op_count_s1, op_count_w;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dwnstrm_sched #(.NUM_REQ(N), .SETTLE_CYCLES(4)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_client_id(req_client_id), .req_amount(req_amount),
      .dp_client_id(dp_client_id), .dp_amount(dp_amount), .dp_start(dp_start),
      .dp_cancelled_orders(dp_cancelled_orders), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_req_idx(rsp_req_idx),
      .rsp_client_id(rsp_client_id), .rsp_cancelled(rsp_cancelled),
      .busy(busy), .op_count(op_count));

   dwnstrm_sched #(.NUM_REQ(N), .SETTLE_CYCLES(1)) u_dut_s1 (
      .clk(clk), .rst(rst), .req_valid(req_valid_s1), .req_ready(req_ready_s1),
      .req_client_id(req_client_id), .req_amount(req_amount),
      .dp_client_id(dp_client_id_s1), .dp_amount(dp_amount_s1), .dp_start(dp_start_s1),
      .dp_cancelled_orders(dp_cancelled_orders), .rsp_valid(rsp_valid_s1),
      .rsp_ready(rsp_ready), .rsp_req_idx(rsp_req_idx_s1),
      .rsp_client_id(rsp_client_id_s1), .rsp_cancelled(rsp_cancelled_s1),
      .busy(busy_s1), .op_count(op_count_s1));

   // Stands in for 65534 completed operations so the wrap is reached quickly.
   dwnstrm_sched #(.NUM_REQ(N), .SETTLE_CYCLES(4), .OP_COUNT_RST(16'hFFFE)) u_dut_w (
      .clk(clk), .rst(rst), .req_valid(req_valid_w), .req_ready(req_ready_w),
      .req_client_id(req_client_id), .req_amount(req_amount),
      .dp_client_id(dp_client_id_w), .dp_amount(dp_amount_w), .dp_start(dp_start_w),
      .dp_cancelled_orders(dp_cancelled_orders), .rsp_valid(rsp_valid_w),
      .rsp_ready(rsp_ready), .rsp_req_idx(rsp_req_idx_w),
      .rsp_client_id(rsp_client_id_w), .rsp_cancelled(rsp_cancelled_w),
      .busy(busy_w), .op_count(op_count_w));

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = '0;
      req_valid_s1 = '0;
      req_valid_w = '0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = '1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({req_ready, dp_client_id, dp_amount, dp_start, rsp_valid, rsp_req_idx,
           rsp_client_id, rsp_cancelled, busy, op_count} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", {req_ready, dp_client_id, dp_amount,
                  dp_start, rsp_valid, rsp_req_idx, rsp_client_id, rsp_cancelled, busy, op_count});
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL reset_first_priority got=%b exp=0001", req_ready);
      end
      req_valid = '0;
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL reset_idle got busy=%b ready=%b exp busy=0 ready=0000", busy, req_ready);
      end
   endtask

   task automatic test_single();
      req_client_id = {5'd0, 5'd0, 5'd0, 5'd3};
      req_amount = {16'd0, 16'd0, 16'd0, 16'd100};
      dp_cancelled_orders = 16'd7;
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL single_grant got=%b exp=0001", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++;
      if ({dp_start, busy, dp_client_id, dp_amount} !== {1'b1, 1'b1, 5'd3, 16'd100}) begin
         failures++;
         $display("FAIL single_issue got start=%b busy=%b id=%0d amt=%0d exp 1 1 3 100",
                  dp_start, busy, dp_client_id, dp_amount);
      end
      for (int c = 2; c <= 5; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({dp_start, rsp_valid, busy} !== 3'b001) begin
            failures++;
            $display("FAIL single_settle_c%0d got start=%b valid=%b busy=%b exp 0 0 1",
                     c, dp_start, rsp_valid, busy);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if ({rsp_valid, rsp_req_idx, rsp_client_id, rsp_cancelled} !== {1'b1, 2'd0, 5'd3, 16'd7}) begin
         failures++;
         $display("FAIL single_resp got valid=%b idx=%0d id=%0d canc=%0d exp 1 0 3 7",
                  rsp_valid, rsp_req_idx, rsp_client_id, rsp_cancelled);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({rsp_valid, busy, op_count, dp_client_id, dp_amount} !== {1'b0, 1'b0, 16'd1, 5'd3, 16'd100}) begin
         failures++;
         $display("FAIL single_done got valid=%b busy=%b cnt=%0d id=%0d amt=%0d exp 0 0 1 3 100",
                  rsp_valid, busy, op_count, dp_client_id, dp_amount);
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [3:0] expv;
      int exp_i;
      int cyc;
      apply_reset();
      req_client_id = {5'd13, 5'd12, 5'd11, 5'd10};
      req_amount = {16'd203, 16'd202, 16'd201, 16'd200};
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      #1;
      for (int g = 0; g < 5; g++) begin
         exp_i = g % 4;
         expv = 4'b0001 << exp_i;
         cyc = 0;
         while (req_ready == 4'b0000 && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
         end
         checks++;
         if (req_ready !== expv) begin
            failures++;
            $display("FAIL rr_grant_%0d got=%b exp=%b", g, req_ready, expv);
         end
         @(negedge clk);
         #1;
         checks++;
         if ({req_ready, dp_start, dp_client_id} !== {4'b0000, 1'b1, 5'(10 + exp_i)}) begin
            failures++;
            $display("FAIL rr_issue_%0d got ready=%b start=%b id=%0d exp 0000 1 %0d",
                     g, req_ready, dp_start, dp_client_id, 10 + exp_i);
         end
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure();
      int cyc;
      apply_reset();
      req_client_id = {5'd0, 5'd21, 5'd0, 5'd0};
      req_amount = {16'd0, 16'd500, 16'd0, 16'd0};
      dp_cancelled_orders = 16'h1234;
      rsp_ready = 1'b0;
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         failures++;
         $display("FAIL bp_grant got=%b exp=0100", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0001;
      cyc = 0;
      while (rsp_valid !== 1'b1 && cyc < 10) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      dp_cancelled_orders = 16'hBEEF;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({rsp_valid, rsp_req_idx, rsp_client_id, rsp_cancelled, busy, req_ready} !==
             {1'b1, 2'd2, 5'd21, 16'h1234, 1'b1, 4'b0000}) begin
            failures++;
            $display("FAIL bp_hold_%0d got valid=%b idx=%0d id=%0d canc=%h busy=%b ready=%b exp 1 2 21 1234 1 0000",
                     c, rsp_valid, rsp_req_idx, rsp_client_id, rsp_cancelled, busy, req_ready);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({rsp_valid, busy, op_count, req_ready} !== {1'b0, 1'b0, 16'd1, 4'b0001}) begin
         failures++;
         $display("FAIL bp_accept got valid=%b busy=%b cnt=%0d ready=%b exp 0 0 1 0001",
                  rsp_valid, busy, op_count, req_ready);
      end
   endtask

   task automatic test_settle();
      apply_reset();
      req_client_id = {5'd0, 5'd0, 5'd0, 5'd4};
      req_amount = '0;
      dp_cancelled_orders = 16'd5;
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      req_valid_s1 = 4'b0001;
      #1;
      checks++;
      if ({req_ready, req_ready_s1} !== {4'b0001, 4'b0001}) begin
         failures++;
         $display("FAIL settle_grant got=%b/%b exp=0001/0001", req_ready, req_ready_s1);
      end
      @(negedge clk);
      req_valid = '0;
      req_valid_s1 = '0;
      #1;
      checks++;
      if ({dp_start, dp_amount, dp_start_s1, dp_amount_s1, dp_client_id_s1} !==
          {1'b1, 16'd0, 1'b1, 16'd0, 5'd4}) begin
         failures++;
         $display("FAIL settle_zero_amount got start=%b amt=%0d start1=%b amt1=%0d id1=%0d exp 1 0 1 0 4",
                  dp_start, dp_amount, dp_start_s1, dp_amount_s1, dp_client_id_s1);
      end
      @(negedge clk);
      @(negedge clk);
      dp_cancelled_orders = 16'd9;
      #1;
      checks++;
      if ({rsp_valid_s1, rsp_cancelled_s1, rsp_req_idx_s1, rsp_client_id_s1, busy_s1} !==
          {1'b1, 16'd5, 2'd0, 5'd4, 1'b1}) begin
         failures++;
         $display("FAIL settle1_capture got valid=%b canc=%0d idx=%0d id=%0d busy=%b exp 1 5 0 4 1",
                  rsp_valid_s1, rsp_cancelled_s1, rsp_req_idx_s1, rsp_client_id_s1, busy_s1);
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({rsp_valid, rsp_cancelled} !== {1'b1, 16'd9}) begin
         failures++;
         $display("FAIL settle4_capture got valid=%b canc=%0d exp 1 9", rsp_valid, rsp_cancelled);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({op_count, op_count_s1, busy_s1} !== {16'd1, 16'd1, 1'b0}) begin
         failures++;
         $display("FAIL settle_done got cnt=%0d cnt1=%0d busy1=%b exp 1 1 0", op_count, op_count_s1, busy_s1);
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int cyc;
      apply_reset();
      req_client_id = {5'd0, 5'd7, 5'd9, 5'd2};
      req_amount = {16'd0, 16'd77, 16'd99, 16'd22};
      dp_cancelled_orders = 16'h0055;
      rsp_ready = 1'b1;
      req_valid = 4'b0100;
      @(negedge clk);
      req_valid = '0;
      repeat (6) @(negedge clk);
      #1;
      checks++;
      if ({op_count, rsp_cancelled} !== {16'd1, 16'h0055}) begin
         failures++;
         $display("FAIL mid_preop got cnt=%0d canc=%h exp 1 0055", op_count, rsp_cancelled);
      end
      req_valid = 4'b0010;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         failures++;
         $display("FAIL mid_grant1 got=%b exp=0010", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0011;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({req_ready, dp_client_id, dp_amount, dp_start, rsp_valid, rsp_req_idx,
           rsp_client_id, rsp_cancelled, busy, op_count} !== '0) begin
         failures++;
         $display("FAIL mid_async_clear got=%h exp=0", {req_ready, dp_client_id, dp_amount,
                  dp_start, rsp_valid, rsp_req_idx, rsp_client_id, rsp_cancelled, busy, op_count});
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL mid_first_after_reset got=%b exp=0001", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0010;
      #1;
      cyc = 0;
      while (req_ready == 4'b0000 && cyc < 20) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      checks++;
      if (req_ready !== 4'b0010) begin
         failures++;
         $display("FAIL mid_second_after_reset got=%b exp=0010", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
   endtask

   task automatic test_wrap();
      apply_reset();
      req_client_id = {5'd0, 5'd0, 5'd17, 5'd30};
      req_amount = {16'd0, 16'd0, 16'd1, 16'hFFFF};
      dp_cancelled_orders = 16'h0042;
      rsp_ready = 1'b1;
      req_valid_w = 4'b0001;
      #1;
      checks++;
      if ({req_ready_w, op_count_w} !== {4'b0001, 16'hFFFE}) begin
         failures++;
         $display("FAIL wrap_start got ready=%b cnt=%h exp 0001 FFFE", req_ready_w, op_count_w);
      end
      @(negedge clk);
      req_valid_w = '0;
      #1;
      checks++;
      if ({dp_start_w, dp_client_id_w, dp_amount_w} !== {1'b1, 5'd30, 16'hFFFF}) begin
         failures++;
         $display("FAIL wrap_issue got start=%b id=%0d amt=%h exp 1 30 FFFF",
                  dp_start_w, dp_client_id_w, dp_amount_w);
      end
      repeat (5) @(negedge clk);
      #1;
      checks++;
      if ({rsp_valid_w, rsp_req_idx_w, rsp_client_id_w, rsp_cancelled_w, busy_w} !==
          {1'b1, 2'd0, 5'd30, 16'h0042, 1'b1}) begin
         failures++;
         $display("FAIL wrap_resp got valid=%b idx=%0d id=%0d canc=%h busy=%b exp 1 0 30 0042 1",
                  rsp_valid_w, rsp_req_idx_w, rsp_client_id_w, rsp_cancelled_w, busy_w);
      end
      @(negedge clk);
      #1;
      checks++;
      if (op_count_w !== 16'hFFFF) begin
         failures++;
         $display("FAIL wrap_ffff got=%h exp=FFFF", op_count_w);
      end
      req_valid_w = 4'b0010;
      #1;
      checks++;
      if (req_ready_w !== 4'b0010) begin
         failures++;
         $display("FAIL wrap_grant2 got=%b exp=0010", req_ready_w);
      end
      @(negedge clk);
      req_valid_w = '0;
      repeat (6) @(negedge clk);
      #1;
      checks++;
      if ({op_count_w, busy_w} !== {16'h0000, 1'b0}) begin
         failures++;
         $display("FAIL wrap_zero got cnt=%h busy=%b exp 0000 0", op_count_w, busy_w);
      end
      rsp_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_settle();
      test_reset_mid();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
